// File: rtl/mccu_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding, opcode/function
// codes, ALU control and mux select codes, and the one-hot instruction flag set.
package mccu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;
  localparam logic [3:0] ALUC_SLT = 4'b1000;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  typedef struct packed {
    logic i_add;  logic i_sub;  logic i_and;  logic i_or;   logic i_xor;
    logic i_slt;  logic i_sll;  logic i_srl;  logic i_sra;  logic i_jr;
    logic i_addi; logic i_andi; logic i_ori;  logic i_xori; logic i_lui;
    logic i_slti; logic i_lw;   logic i_sw;   logic i_beq;  logic i_bne;
    logic i_j;    logic i_jal;
  } instr_t;

  // Branch compares use the xor encoding; the zero flag then means "equal".
  function automatic logic [3:0] alu_ctl(input instr_t d);
    if (d.i_add || d.i_addi || d.i_lw || d.i_sw) return ALUC_ADD;
    else if (d.i_sub)                            return ALUC_SUB;
    else if (d.i_and || d.i_andi)                return ALUC_AND;
    else if (d.i_or  || d.i_ori)                 return ALUC_OR;
    else if (d.i_xor || d.i_xori || d.i_beq || d.i_bne) return ALUC_XOR;
    else if (d.i_lui)                            return ALUC_LUI;
    else if (d.i_sll)                            return ALUC_SLL;
    else if (d.i_srl)                            return ALUC_SRL;
    else if (d.i_sra)                            return ALUC_SRA;
    else if (d.i_slt || d.i_slti)                return ALUC_SLT;
    else                                         return ALUC_ADD;
  endfunction

endpackage

// File: rtl/mccu_decode.sv
// Combinational instruction decode: op/func to one-hot flags plus an illegal indication.
// slt/slti are only recognised when MCCU_SLT_EN is defined.
module mccu_decode
  import mccu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output instr_t     dec,
  output logic       illegal
);

  logic rtype;
  assign rtype = (op == OP_RTYPE);

  always_comb begin
    dec        = '0;
    dec.i_add  = rtype && (func == FN_ADD);
    dec.i_sub  = rtype && (func == FN_SUB);
    dec.i_and  = rtype && (func == FN_AND);
    dec.i_or   = rtype && (func == FN_OR);
    dec.i_xor  = rtype && (func == FN_XOR);
    dec.i_sll  = rtype && (func == FN_SLL);
    dec.i_srl  = rtype && (func == FN_SRL);
    dec.i_sra  = rtype && (func == FN_SRA);
    dec.i_jr   = rtype && (func == FN_JR);
    dec.i_addi = (op == OP_ADDI);
    dec.i_andi = (op == OP_ANDI);
    dec.i_ori  = (op == OP_ORI);
    dec.i_xori = (op == OP_XORI);
    dec.i_lui  = (op == OP_LUI);
    dec.i_lw   = (op == OP_LW);
    dec.i_sw   = (op == OP_SW);
    dec.i_beq  = (op == OP_BEQ);
    dec.i_bne  = (op == OP_BNE);
    dec.i_j    = (op == OP_J);
    dec.i_jal  = (op == OP_JAL);
`ifdef MCCU_SLT_EN
    dec.i_slt  = rtype && (func == FN_SLT);
    dec.i_slti = (op == OP_SLTI);
`else
    dec.i_slt  = 1'b0;
    dec.i_slti = 1'b0;
`endif
    illegal    = (dec == '0);
  end

endmodule

// File: rtl/mccu_fsm.sv
// Multi-cycle control FSM (IF/ID/EXE/MEM/WB) with memory-ready handshake, timeout abort,
// illegal-opcode flag and retired-instruction counter. Optional slt/slti via MCCU_SLT_EN.
module mccu_fsm
  import mccu_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_ready,
  output logic             wpc,
  output logic             wir,
  output logic             wmem,
  output logic             wreg,
  output logic             iord,
  output logic             regrt,
  output logic             m2reg,
  output logic             jal,
  output logic             shift,
  output logic             sext,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsource,
  output logic [2:0]       state,
  output logic             ill_instr,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WC_W'(MEM_TIMEOUT - 1) : '0;

  state_t          cur, nxt;
  logic [WC_W-1:0] wait_cnt;
  instr_t          dec;
  logic            illegal;
  logic            rdy, waiting, timeout, retire;
  logic            itype, immsrc;
  logic            wpc_c, wir_c, wmem_c, wreg_c, ill_c, err_c;

  mccu_decode u_decode (
    .op      (op),
    .func    (func),
    .dec     (dec),
    .illegal (illegal)
  );

  assign rdy     = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign waiting = ((cur == S_IF) || (cur == S_MEM)) && !rdy;
  assign timeout = (MEM_TIMEOUT > 0) && waiting && (wait_cnt == WAIT_LAST);
  assign itype   = dec.i_addi | dec.i_andi | dec.i_ori | dec.i_xori | dec.i_lui |
                   dec.i_lw | dec.i_slti;
  assign immsrc  = itype | dec.i_sw;
  assign state   = cur;

  // Enables and pulses are forced low while clrn is asserted, not just after the next edge.
  assign wpc       = wpc_c  & clrn;
  assign wir       = wir_c  & clrn;
  assign wmem      = wmem_c & clrn;
  assign wreg      = wreg_c & clrn;
  assign ill_instr = ill_c  & clrn;
  assign mem_err   = err_c  & clrn;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cur       <= S_IF;
      wait_cnt  <= '0;
      instr_cnt <= '0;
    end else begin
      cur       <= nxt;
      wait_cnt  <= (waiting && !timeout) ? wait_cnt + WC_W'(1) : '0;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt      = cur;
    retire   = 1'b0;
    wpc_c    = 1'b0;
    wir_c    = 1'b0;
    wmem_c   = 1'b0;
    wreg_c   = 1'b0;
    ill_c    = 1'b0;
    err_c    = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REGB;
    aluc     = ALUC_ADD;
    pcsource = PC_ALU;
    sext     = dec.i_addi | dec.i_lw | dec.i_sw | dec.i_beq | dec.i_bne | dec.i_slti;
    unique case (cur)
      S_IF: begin
        alusrcb = SRCB_FOUR;
        wpc_c   = rdy;
        wir_c   = rdy;
        if (rdy)          nxt = S_ID;
        else if (timeout) err_c = 1'b1;
      end
      S_ID: begin
        alusrcb = SRCB_BR;
        if (illegal) begin
          ill_c = 1'b1;
          nxt   = S_IF;
        end else if (dec.i_j || dec.i_jal) begin
          wpc_c    = 1'b1;
          pcsource = PC_JUMP;
          wreg_c   = dec.i_jal;
          jal      = dec.i_jal;
          retire   = 1'b1;
          nxt      = S_IF;
        end else if (dec.i_jr) begin
          wpc_c    = 1'b1;
          pcsource = PC_RS;
          retire   = 1'b1;
          nxt      = S_IF;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        alusrcb = immsrc ? SRCB_IMM : SRCB_REGB;
        shift   = dec.i_sll | dec.i_srl | dec.i_sra;
        aluc    = alu_ctl(dec);
        if (dec.i_beq || dec.i_bne) begin
          pcsource = PC_BRANCH;
          wpc_c    = (dec.i_beq & z) | (dec.i_bne & ~z);
          retire   = 1'b1;
          nxt      = S_IF;
        end else if (dec.i_lw || dec.i_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (rdy) begin
          wmem_c = dec.i_sw;
          retire = dec.i_sw;
          nxt    = dec.i_sw ? S_IF : S_WB;
        end else if (timeout) begin
          err_c = 1'b1;
          nxt   = S_IF;
        end else begin
          wmem_c = dec.i_sw;
        end
      end
      S_WB: begin
        wreg_c = 1'b1;
        regrt  = itype;
        m2reg  = dec.i_lw;
        retire = 1'b1;
        nxt    = S_IF;
      end
      default: nxt = S_IF;
    endcase
  end

endmodule

// File: tb/tb_mccu_fsm.sv
// Self-checking bench for mccu_fsm: directed scenarios then random instruction streams,
// checked against an instruction-level phase model built from the control rules.
module tb_mccu_fsm;

  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EXE = 3'd2, ST_MEM = 3'd3, ST_WB = 3'd4;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic z = 1'b0, mem_ready = 1'b0;
  logic wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;
  logic ill_instr, mem_err;
  logic [CW-1:0] instr_cnt;

  mccu_fsm #(.USE_MEM_READY(1), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .state(state),
    .ill_instr(ill_instr), .mem_err(mem_err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {K_RALU, K_SHIFT, K_IMM, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JR, K_JAL, K_ILL} kind_e;
  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    kind_e      kind;
    logic [3:0] aluc;
    logic       sext;
  } ientry_t;

  ientry_t tbl[$];
  ientry_t cur_e;

  int n_cmp = 0, n_fail = 0;
  int exp_cnt = 0;

  logic [2:0] e_state;
  logic e_wpc, e_wir, e_wmem, e_wreg, e_iord, e_regrt, e_m2reg, e_jal, e_shift, e_sext, e_alusrca;
  logic [1:0] e_alusrcb, e_pcsource;
  logic [3:0] e_aluc;
  logic e_ill, e_merr;

  function automatic void add_e(logic [5:0] o, logic [5:0] f, kind_e k, logic [3:0] a, logic s);
    ientry_t t;
    t.op = o; t.func = f; t.kind = k; t.aluc = a; t.sext = s;
    tbl.push_back(t);
  endfunction

  function automatic int find(logic [5:0] o, logic [5:0] f);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].op == o && tbl[i].func == f) return i;
    return 0;
  endfunction

  task automatic set_base(input logic [2:0] st);
    e_state = st;
    {e_wpc, e_wir, e_wmem, e_wreg, e_iord, e_regrt, e_m2reg, e_jal, e_shift, e_alusrca} = '0;
    e_sext = cur_e.sext;
    e_alusrcb = 2'b00; e_pcsource = 2'b00; e_aluc = 4'b0000;
    e_ill = 1'b0; e_merr = 1'b0;
  endtask

  task automatic check_now(input string tag);
    logic [23:0] obs, expv;
    obs  = {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca,
            alusrcb, aluc, pcsource, ill_instr, mem_err};
    expv = {e_state, e_wpc, e_wir, e_wmem, e_wreg, e_iord, e_regrt, e_m2reg, e_jal, e_shift,
            e_sext, e_alusrca, e_alusrcb, e_aluc, e_pcsource, e_ill, e_merr};
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %h expected %h (op %h func %h)", tag, obs, expv, op, func);
    end
    n_cmp++;
    assert (instr_cnt === CW'(exp_cnt)) else begin
      n_fail++;
      $error("FAIL %s instr_cnt: observed %0d expected %0d", tag, instr_cnt, CW'(exp_cnt));
    end
  endtask

  // Called just after a rising edge: apply inputs, check mid-cycle, advance to next edge.
  task automatic step(input string tag, input logic rdy);
    mem_ready = rdy;
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_if(input int waits);
    int waited = 0;
    for (int k = 0; k < waits; k++) begin
      set_base(ST_IF); e_alusrcb = 2'b01;
      if (waited == TMO - 1) e_merr = 1'b1;
      step("if_wait", 1'b0);
      waited = (waited == TMO - 1) ? 0 : waited + 1;
    end
    set_base(ST_IF); e_alusrcb = 2'b01; e_wpc = 1'b1; e_wir = 1'b1;
    step("if_fetch", 1'b1);
  endtask

  task automatic run_instr(input int idx, input int if_wait, input int mem_wait,
                           input logic zz, input bit rst_in_mem);
    kind_e k;
    cur_e = tbl[idx];
    k = cur_e.kind;
    op = cur_e.op; func = cur_e.func; z = zz;
    do_if(if_wait);
    // decode
    set_base(ST_ID); e_alusrcb = 2'b11;
    case (k)
      K_J:   begin e_wpc = 1'b1; e_pcsource = 2'b11; end
      K_JR:  begin e_wpc = 1'b1; e_pcsource = 2'b10; end
      K_JAL: begin e_wpc = 1'b1; e_pcsource = 2'b11; e_wreg = 1'b1; e_jal = 1'b1; end
      K_ILL: e_ill = 1'b1;
      default: ;
    endcase
    step("id", 1'($urandom % 2));
    if (k == K_ILL) return;
    if (k == K_J || k == K_JR || k == K_JAL) begin exp_cnt = (exp_cnt + 1) % (1 << CW); return; end
    // execute
    set_base(ST_EXE); e_alusrca = 1'b1; e_aluc = cur_e.aluc;
    e_alusrcb = (k == K_IMM || k == K_LW || k == K_SW) ? 2'b10 : 2'b00;
    e_shift = (k == K_SHIFT);
    if (k == K_BEQ || k == K_BNE) begin
      e_pcsource = 2'b01;
      e_wpc = (k == K_BEQ) ? zz : ~zz;
    end
    step("exe", 1'($urandom % 2));
    if (k == K_BEQ || k == K_BNE) begin exp_cnt = (exp_cnt + 1) % (1 << CW); return; end
    if (k == K_LW || k == K_SW) begin
      if (rst_in_mem) begin
        set_base(ST_MEM); e_iord = 1'b1; e_wmem = (k == K_SW);
        mem_ready = 1'b0;
        @(negedge clk);
        check_now("mem_pre_rst");
        #2 clrn = 1'b0;
        #1;
        exp_cnt = 0;
        set_base(ST_IF); e_alusrcb = 2'b01;
        check_now("rst_async");
        @(posedge clk);
        #1 clrn = 1'b1;
        check_now("rst_release");
        return;
      end
      for (int w = 0; w < mem_wait; w++) begin
        set_base(ST_MEM); e_iord = 1'b1;
        if (w == TMO - 1) begin
          e_merr = 1'b1;
          step("mem_timeout", 1'b0);
          return;
        end
        e_wmem = (k == K_SW);
        step("mem_wait", 1'b0);
      end
      set_base(ST_MEM); e_iord = 1'b1; e_wmem = (k == K_SW);
      step("mem_done", 1'b1);
      if (k == K_SW) begin exp_cnt = (exp_cnt + 1) % (1 << CW); return; end
    end
    // write back
    set_base(ST_WB); e_wreg = 1'b1;
    e_regrt = (k == K_IMM || k == K_LW);
    e_m2reg = (k == K_LW);
    step("wb", 1'($urandom % 2));
    exp_cnt = (exp_cnt + 1) % (1 << CW);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add_e(6'h00, 6'h20, K_RALU,  4'b0000, 1'b0); // add
    add_e(6'h00, 6'h22, K_RALU,  4'b0100, 1'b0); // sub
    add_e(6'h00, 6'h24, K_RALU,  4'b0001, 1'b0); // and
    add_e(6'h00, 6'h25, K_RALU,  4'b0101, 1'b0); // or
    add_e(6'h00, 6'h26, K_RALU,  4'b0010, 1'b0); // xor
    add_e(6'h00, 6'h00, K_SHIFT, 4'b0011, 1'b0); // sll
    add_e(6'h00, 6'h02, K_SHIFT, 4'b0111, 1'b0); // srl
    add_e(6'h00, 6'h03, K_SHIFT, 4'b1111, 1'b0); // sra
    add_e(6'h00, 6'h08, K_JR,    4'b0000, 1'b0); // jr
    add_e(6'h08, 6'h15, K_IMM,   4'b0000, 1'b1); // addi
    add_e(6'h0c, 6'h01, K_IMM,   4'b0001, 1'b0); // andi
    add_e(6'h0d, 6'h07, K_IMM,   4'b0101, 1'b0); // ori
    add_e(6'h0e, 6'h2a, K_IMM,   4'b0010, 1'b0); // xori
    add_e(6'h0f, 6'h00, K_IMM,   4'b0110, 1'b0); // lui
    add_e(6'h23, 6'h04, K_LW,    4'b0000, 1'b1); // lw
    add_e(6'h2b, 6'h10, K_SW,    4'b0000, 1'b1); // sw
    add_e(6'h04, 6'h3c, K_BEQ,   4'b0010, 1'b1); // beq
    add_e(6'h05, 6'h08, K_BNE,   4'b0010, 1'b1); // bne
    add_e(6'h02, 6'h11, K_J,     4'b0000, 1'b0); // j
    add_e(6'h03, 6'h20, K_JAL,   4'b0000, 1'b0); // jal
    add_e(6'h3f, 6'h20, K_ILL,   4'b0000, 1'b0); // undefined opcode
    add_e(6'h00, 6'h3f, K_ILL,   4'b0000, 1'b0); // undefined function
`ifdef MCCU_SLT_EN
    add_e(6'h00, 6'h2a, K_RALU,  4'b1000, 1'b0); // slt
    add_e(6'h0a, 6'h05, K_IMM,   4'b1000, 1'b1); // slti
`else
    add_e(6'h00, 6'h2a, K_ILL,   4'b0000, 1'b0); // slt
    add_e(6'h0a, 6'h05, K_ILL,   4'b0000, 1'b0); // slti
`endif

    // reset: enables stay low even with mem_ready high
    cur_e = tbl[0];
    op = 6'h00; func = 6'h20; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    set_base(ST_IF); e_alusrcb = 2'b01;
    check_now("reset");
    @(posedge clk);
    #1 clrn = 1'b1;

    run_instr(find(6'h00, 6'h20), 0, 0, 1'b0, 1'b0); // add
    run_instr(find(6'h23, 6'h04), 0, 3, 1'b0, 1'b0); // lw with memory stall
    run_instr(find(6'h04, 6'h3c), 0, 0, 1'b1, 1'b0); // beq taken
    run_instr(find(6'h05, 6'h08), 0, 0, 1'b1, 1'b0); // bne not taken
    run_instr(find(6'h2b, 6'h10), 0, 4, 1'b0, 1'b0); // sw timeout
    run_instr(find(6'h3f, 6'h20), 0, 0, 1'b0, 1'b0); // illegal opcode
    run_instr(find(6'h00, 6'h2a), 0, 0, 1'b0, 1'b0); // slt
    run_instr(find(6'h0a, 6'h05), 0, 1, 1'b0, 1'b0); // slti
    run_instr(find(6'h03, 6'h20), 5, 0, 1'b0, 1'b0); // jal after an IF timeout
    run_instr(find(6'h00, 6'h08), 0, 0, 1'b0, 1'b0); // jr
    run_instr(find(6'h02, 6'h11), 3, 0, 1'b0, 1'b0); // j with longest non-aborting IF stall
    run_instr(find(6'h2b, 6'h10), 0, 0, 1'b0, 1'b1); // sw with reset in MEM
    run_instr(find(6'h00, 6'h20), 0, 0, 1'b0, 1'b0); // add after reset counts from 0

    for (int n = 0; n < 80; n++)
      run_instr(int'($urandom % tbl.size()), int'($urandom % 6), int'($urandom % 6),
                1'($urandom % 2), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
